shift_reg_univ: RTL

Parametrised universal shift register that succeeds the fixed 4-bit serial/parallel register on the board top level. It adds configurable width, eight operating modes (shift, rotate, arithmetic shift, load, clear), a shift counter with a word-complete flag for serial-to-parallel capture, and an optional registered seven-segment output. It sits between the switch bank and the LED/SEG displays in `top`. The same block is reused as a serial link front end.

---
 rtl/shift_reg_univ.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/shift_reg_univ.sv
// Purpose  : parametrised universal shift register (shift/rotate/arith-shift/load/clear)
//            with a saturating shift counter and word-complete flag.
// Latency  : 1 cycle, all outputs registered; backpressure: none, en=0 freezes all state.
// Ports    : clk_2, reset_n (async, active-low), en, mode[2:0], serial_in, par_in[NBITS-1:0]
//            -> q[NBITS-1:0], serial_out, shift_cnt[$clog2(NBITS+1)-1:0], full,
//            seg[7:0] (only when SHREG_SEG_EN is defined: seven-segment code of q[3:0]).
module shift_reg_univ #(
    parameter int                NBITS     = 8,
    parameter logic [NBITS-1:0]  RESET_REG = '0
) (
    input  logic                         clk_2,
    input  logic                         reset_n,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic                         serial_in,
    input  logic [NBITS-1:0]             par_in,
    output logic [NBITS-1:0]             q,
    output logic                         serial_out,
    output logic [$clog2(NBITS+1)-1:0]   shift_cnt,
`ifdef SHREG_SEG_EN
    output logic [7:0]                   seg,
`endif
    output logic                         full
);

    localparam int             CW      = $clog2(NBITS+1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(NBITS);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    logic [NBITS-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             shift_op;

    always_comb begin
        q_d      = q_q;
        so_d     = so_q;
        cnt_d    = cnt_q;
        shift_op = 1'b0;
        if (en) begin
            case (mode_e'(mode))
                MODE_SHL: begin
                    q_d      = {q_q[NBITS-2:0], serial_in};
                    so_d     = q_q[NBITS-1];
                    shift_op = 1'b1;
                end
                MODE_SHR: begin
                    q_d      = {serial_in, q_q[NBITS-1:1]};
                    so_d     = q_q[0];
                    shift_op = 1'b1;
                end
                MODE_ROL: begin
                    q_d      = {q_q[NBITS-2:0], q_q[NBITS-1]};
                    so_d     = q_q[NBITS-1];
                    shift_op = 1'b1;
                end
                MODE_ROR: begin
                    q_d      = {q_q[0], q_q[NBITS-1:1]};
                    so_d     = q_q[0];
                    shift_op = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = par_in;
                    cnt_d = '0;
                end
                MODE_ASR: begin
                    q_d      = {q_q[NBITS-1], q_q[NBITS-1:1]};
                    so_d     = q_q[0];
                    shift_op = 1'b1;
                end
                MODE_CLEAR: begin
                    q_d   = RESET_REG;
                    so_d  = 1'b0;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
        // Counter saturates so a long serial stream never makes full flicker.
        if (shift_op && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Derived from next count so full is aligned with shift_cnt.
        full_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= RESET_REG;
            so_q   <= 1'b0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            so_q   <= so_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign q          = q_q;
    assign serial_out = so_q;
    assign shift_cnt  = cnt_q;
    assign full       = full_q;

`ifdef SHREG_SEG_EN
    function automatic logic [7:0] seg7(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0: code = 8'h3f;  4'h1: code = 8'h06;  4'h2: code = 8'h5b;  4'h3: code = 8'h4f;
            4'h4: code = 8'h66;  4'h5: code = 8'h6d;  4'h6: code = 8'h7d;  4'h7: code = 8'h07;
            4'h8: code = 8'h7f;  4'h9: code = 8'h6f;  4'ha: code = 8'h77;  4'hb: code = 8'h7c;
            4'hc: code = 8'h39;  4'hd: code = 8'h5e;  4'he: code = 8'h79;  default: code = 8'h71;
        endcase
        return code;
    endfunction

    logic [7:0] seg_q;

    // Decoded from next-state q so the display lines up with q, not one cycle behind.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            seg_q <= seg7(4'(RESET_REG));
        end else begin
            seg_q <= seg7(4'(q_d));
        end
    end

    assign seg = seg_q;
`endif

endmodule
